// File: rtl/jedro_1_mem_arbiter.sv
// Single-port data-memory arbiter for jedro-1: IFU vs LSU, one transaction outstanding, response timeout.
// Optional round-robin arbitration on simultaneous requests when JEDRO_1_ARB_RR_EN is defined (else LSU has fixed priority).
module jedro_1_mem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ifu_req_i,
    input  logic [ADDR_WIDTH-1:0] ifu_addr_i,
    output logic                  ifu_gnt_o,
    output logic                  ifu_rvalid_o,
    output logic [DATA_WIDTH-1:0] ifu_rdata_o,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [3:0]            lsu_be_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_gnt_o,
    output logic                  lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  err_o
);

    localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;
    typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_t;

    state_t                state_r, state_s;
    owner_t                owner_r, sel_s;
    logic [CNT_W-1:0]      cnt_r;
    logic                  timeout_s;
    logic                  gnt_s;
    logic                  rsp_s;
    logic [DATA_WIDTH-1:0] rsp_data_s;

`ifdef JEDRO_1_ARB_RR_EN
    owner_t last_owner_r;

    // Remember who was served last so a contended request alternates owners.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_owner_r <= OWN_LSU;
        end else if ((state_r == IDLE) && (state_s == REQ)) begin
            last_owner_r <= sel_s;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end
`endif

    // Pick the owner of the next transaction from the pending requests.
    always_comb begin
        sel_s = OWN_IFU;
        if (ifu_req_i && lsu_req_i) begin
`ifdef JEDRO_1_ARB_RR_EN
            sel_s = (last_owner_r == OWN_IFU) ? OWN_LSU : OWN_IFU;
`else
            sel_s = OWN_LSU;
`endif
        end else if (lsu_req_i) begin
            sel_s = OWN_LSU;
        end else begin
            sel_s = OWN_IFU;
        end
    end

    // Next-state logic and response-timeout detection.
    always_comb begin
        state_s   = state_r;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (ifu_req_i || lsu_req_i) state_s = REQ;
                else                        state_s = IDLE;
            end
            REQ: begin
                if (mem_gnt_i) state_s = RSP;
                else           state_s = REQ;
            end
            RSP: begin
                if (mem_rvalid_i) begin
                    state_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = RSP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, owner, timeout counter and registered memory request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            owner_r     <= OWN_IFU;
            cnt_r       <= {CNT_W{1'b0}};
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_addr_o  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_o <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (state_s == REQ) begin
                        owner_r   <= sel_s;
                        mem_req_o <= 1'b1;
                        if (sel_s == OWN_LSU) begin
                            mem_we_o    <= lsu_we_i;
                            mem_be_o    <= lsu_be_i;
                            mem_addr_o  <= lsu_addr_i;
                            mem_wdata_o <= lsu_wdata_i;
                        end else begin
                            mem_we_o    <= 1'b0;
                            mem_be_o    <= 4'b1111;
                            mem_addr_o  <= ifu_addr_i;
                            mem_wdata_o <= {DATA_WIDTH{1'b0}};
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        cnt_r     <= {CNT_W{1'b0}};
                    end
                end
                RSP: begin
                    // Saturating count; the timeout exit normally fires first.
                    if (!mem_rvalid_i && (cnt_r != CNT_MAX)) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

    // Grant and response are steered to the owner; a reset cycle suppresses them.
    assign gnt_s      = !rst_i && (state_r == REQ) && mem_gnt_i;
    assign rsp_s      = !rst_i && (state_r == RSP) && (mem_rvalid_i || timeout_s);
    assign rsp_data_s = (rsp_s && mem_rvalid_i) ? mem_rdata_i : {DATA_WIDTH{1'b0}};

    assign ifu_gnt_o    = gnt_s && (owner_r == OWN_IFU);
    assign lsu_gnt_o    = gnt_s && (owner_r == OWN_LSU);
    assign ifu_rvalid_o = rsp_s && (owner_r == OWN_IFU);
    assign lsu_rvalid_o = rsp_s && (owner_r == OWN_LSU);
    assign ifu_rdata_o  = (owner_r == OWN_IFU) ? rsp_data_s : {DATA_WIDTH{1'b0}};
    assign lsu_rdata_o  = (owner_r == OWN_LSU) ? rsp_data_s : {DATA_WIDTH{1'b0}};
    assign err_o        = rsp_s && timeout_s;

endmodule

// File: doc/jedro_1_mem_arbiter.md
# jedro_1_mem_arbiter

Arbitrates the single data-memory port of the jedro-1 core between the instruction fetch unit (IFU) and the load-store unit (LSU). It sequences each transaction through request, grant and response phases with one transaction outstanding. It routes the response back to the owning requester and recovers from a memory that never responds using a response timeout. It sits between the IFU/LSU and the external memory interface.

## Interface
- DATA_WIDTH, 32: data bus width.
- ADDR_WIDTH, 32: address bus width.
- RSP_TIMEOUT, 255: cycles to wait in RSP before aborting; must be ≥1.

- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- ifu_req_i  in  1  IFU read request; held with ifu_addr_i stable until ifu_gnt_o.
- ifu_addr_i  in  ADDR_WIDTH  IFU address.
- ifu_gnt_o  out  1  one-cycle pulse: IFU request accepted by memory.
- ifu_rvalid_o  out  1  one-cycle pulse: ifu_rdata_o valid.
- ifu_rdata_o  out  DATA_WIDTH  IFU read data.
- lsu_req_i  in  1  LSU request; lsu_we_i/be/addr/wdata held stable until lsu_gnt_o.
- lsu_we_i  in  1  1 = store.
- lsu_be_i  in  4  byte enables.
- lsu_addr_i  in  ADDR_WIDTH  LSU address.
- lsu_wdata_i  in  DATA_WIDTH  store data.
- lsu_gnt_o  out  1  one-cycle pulse: LSU request accepted.
- lsu_rvalid_o  out  1  one-cycle pulse: LSU response (loads and stores).
- lsu_rdata_o  out  DATA_WIDTH  load data.
- mem_req_o, mem_we_o, mem_be_o[3:0], mem_addr_o, mem_wdata_o  out  registered memory request.
- mem_gnt_i  in  1  memory accepts request.
- mem_rvalid_i  in  1  memory response valid (reads and writes).
- mem_rdata_i  in  DATA_WIDTH  memory read data.
- err_o  out  1  one-cycle pulse on response timeout.

## Operation
- States: IDLE, REQ, RSP. Reset state IDLE.
- IDLE: if any request, select owner, latch owner's fields into mem_* registers, mem_req_o←1, go REQ. IFU requests drive mem_we_o=0, mem_be_o=4'b1111, mem_wdata_o=0.
- Arbitration on simultaneous requests: see Configuration. A single request always wins.
- REQ: mem_req_o and all mem_* fields held stable. On mem_gnt_i: owner gnt_o=1 (combinational, that cycle), mem_req_o←0, timeout counter←0, go RSP.
- RSP: owner rvalid_o = mem_rvalid_i; owner rdata_o = mem_rdata_i (combinational). On mem_rvalid_i, go IDLE. Otherwise counter increments; when it reaches RSP_TIMEOUT-1 without rvalid: owner rvalid_o=1, owner rdata_o=0, err_o=1, go IDLE.
- Non-owner gnt/rvalid always 0; rdata_o is 0 whenever its rvalid_o is 0.
- mem_gnt_i outside REQ and mem_rvalid_i outside RSP are ignored. A late rvalid after timeout is discarded.
- Counter width $clog2(RSP_TIMEOUT+1); saturates, never wraps.

## Timing
- Reset values: all *_gnt_o, *_rvalid_o, err_o, mem_req_o, mem_we_o = 0; mem_be_o, mem_addr_o, mem_wdata_o = 0; *_rdata_o = 0; owner = IFU; last_owner = LSU.
- rst_i asserted in any state: next cycle IDLE, all outputs at reset values, and the in-flight transaction is abandoned with no rvalid or err.
- Request seen in IDLE at cycle N: mem_req_o=1 at N+1. gnt_o occurs in the first cycle ≥N+1 with mem_gnt_i. rvalid_o occurs in the first cycle after the grant with mem_rvalid_i. IDLE is entered the cycle after rvalid.
- Minimum transaction period 3 cycles (IDLE, REQ, RSP). Maximum time in RSP is RSP_TIMEOUT cycles.
- A requester that deasserts req before gnt is still granted once latched; requesters must not withdraw.

## Configuration
- JEDRO_1_ARB_RR_EN defined: round-robin. On simultaneous requests, grant the requester that is not last_owner. last_owner updates at each IDLE→REQ.
- Undefined: fixed priority. LSU wins all simultaneous requests; last_owner is unused.

## Test plan
- IFU read only, addr 0x100, mem_gnt_i same cycle as mem_req_o, rvalid next cycle with 0xDEADBEEF -> ifu_gnt_o at N+1, ifu_rvalid_o at N+2 with 0xDEADBEEF, lsu_* outputs stay 0.
- LSU store addr 0x2000, wdata 0x12345678, be 4'b0011, gnt delayed 3 cycles -> mem_* fields stable across all 3 cycles, lsu_gnt_o one pulse, lsu_rvalid_o on write ack.
- Both requesting continuously for 4 transactions -> with RR_EN, owner order IFU, LSU, IFU, LSU; without it, LSU ×4 and IFU starved.
- RSP_TIMEOUT=4, no mem_rvalid_i -> after 4 RSP cycles owner rvalid_o=1, rdata 0, err_o=1; a late mem_rvalid_i is ignored and no rvalid pulses.
- rst_i pulsed while in RSP -> IDLE next cycle, all outputs 0, and a subsequent mem_rvalid_i is ignored.
